mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 256: max consecutive waitrequest-high cycles tolerated in BUS; 0 = unlimited.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  CPU access request present.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 req_signed  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-009 req_addr  in  32  byte address of access.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and faults.
REQ-013 resp_fault  out  1  access failed (misaligned or bus timeout), valid with resp_valid.
REQ-014 address  out  32  bus word address, req_addr with bits [1:0] forced to 0.
REQ-015 read / write  out  1 each  bus strobes; never both high.
REQ-016 byteenable  out  4  active byte lanes, lane n = bits [8n+7:8n].
REQ-017 writedata  out  32  lane-replicated store data.
REQ-018 readdata  in  32  bus read data, registered by slave, valid the cycle after the accepting cycle.
REQ-019 waitrequest  in  1  slave stall; transfer accepted in any BUS cycle where it is 0.

Function
REQ-020 FSM states IDLE, BUS, DATA, RESP; request accepted on a clk edge with req_valid && req_ready, all request fields registered then.
REQ-021 IDLE -> BUS on accept; BUS holds address, byteenable, writedata, strobe stable until acceptance.
REQ-022 BUS, waitrequest=0: store -> RESP; load -> DATA; strobe deasserted from next cycle.
REQ-023 DATA lasts exactly one cycle; readdata sampled at its closing edge; -> RESP.
REQ-024 RESP asserts resp_valid for exactly one cycle, then -> IDLE; resp_* hold value until next RESP.
REQ-025 Latency, zero wait: store resp_valid 2 cycles after accept edge, load 3 cycles; each waitrequest cycle adds one.
REQ-026 byteenable: byte = 1 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-027 writedata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-028 Load extraction: byte from lane addr[1:0], half from lane pair addr[1]; extended to 32 bits per req_signed; word unchanged.
REQ-029 Timeout: counter cleared on entering BUS, increments each BUS cycle with waitrequest=1; reaching WAIT_LIMIT (nonzero) drops strobe, -> RESP with resp_fault=1.
REQ-030 waitrequest falling in the same cycle the counter reaches WAIT_LIMIT: transfer accepted, no fault.
REQ-031 req_valid ignored outside IDLE; no request queuing.

Reset
REQ-032 reset forces IDLE immediately; read, write, resp_valid, resp_fault = 0; resp_rdata, address, writedata = 0; byteenable = 0000; counter = 0.
REQ-033 Reset mid-transfer abandons it with no response; first request after release is accepted normally.

Configuration
REQ-034 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word/reserved with addr[1:0]!=00 issues no bus cycle, IDLE -> RESP directly, resp_fault=1, resp_rdata=0.
REQ-035 Macro undefined: no alignment check; half ignores addr[0], word ignores addr[1:0]; resp_fault only from timeout.

Verification
REQ-036 Store word 0xDEADBEEF to 0xBFC00010, waitrequest=0 -> one write cycle, address 0xBFC00010, byteenable 1111, resp_valid 2 cycles after accept, fault 0.
REQ-037 Load signed byte from 0xBFC00013, readdata 0x80112233 -> byteenable 1000, resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Store half 0x1234 to 0xBFC00002, waitrequest high 3 cycles -> write held 4 cycles, byteenable 1100, writedata 0x12341234, resp_valid 5 cycles after accept.
REQ-039 WAIT_LIMIT=4, waitrequest stuck high -> strobe drops after 4 BUS cycles, resp_valid with resp_fault=1, resp_rdata 0.
REQ-040 MEM_ALIGN_CHECK_EN defined, load word from 0xBFC00001 -> no read strobe, resp_valid next cycle after accept, resp_fault=1.
REQ-041 reset pulsed while read=1 in BUS -> read=0 same cycle, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-oriented memory bus between mem_access_unit (master) and a memory slave.
// The slave stalls with waitrequest and returns registered readdata one cycle
// after it accepts a read.
interface mem_access_unit_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one CPU load/store request into one word-bus transfer.
// Sub-word stores are lane-replicated with byte enables; loads are extracted
// from the addressed lane and sign/zero extended. A stalled transfer is
// abandoned with a fault after WAIT_LIMIT waitrequest cycles (0 = never).
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word requests fault
// immediately without touching the bus.
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_fault,
  mem_access_unit_if.master  bus
);

  localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUS, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] writedata_q, writedata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misaligned;
  logic        wait_expired;

  // Active byte lanes for a request of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Copies right-aligned store data onto every lane it could land on.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   replicate = {4{data[7:0]}};
      2'b01:   replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

  // Pulls the addressed lane(s) out of a bus word and extends to 32 bits.
  function automatic logic [31:0] extract(input logic [1:0] size, input logic sgn,
                                          input logic [1:0] off, input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (size)
      2'b00:   extract = {{24{sgn & b[7]}}, b};
      2'b01:   extract = {{16{sgn & h[15]}}, h};
      default: extract = data;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Half needs an even address; word (and reserved, treated as word) needs a word address.
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  // Without the check, sub-word offset bits beyond the access size are simply ignored.
  assign misaligned = 1'b0;
`endif

  // The stall that would bring the counter up to WAIT_LIMIT ends the transfer.
  assign wait_expired = (WAIT_LIMIT != 0) && ((32'(wait_cnt_q) + 32'd1) == WAIT_LIMIT);

  // Next-state and next-output logic for the whole access sequence.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    is_write_d   = is_write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    offset_d     = offset_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    read_d       = read_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_fault_d = resp_fault_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_write_d = req_write;
          size_d     = req_size;
          signed_d   = req_signed;
          offset_d   = req_addr[1:0];
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d      = BUS;
            wait_cnt_d   = '0;
            address_d    = {req_addr[31:2], 2'b00};
            byteenable_d = lane_mask(req_size, req_addr[1:0]);
            writedata_d  = replicate(req_size, req_wdata);
            read_d       = ~req_write;
            write_d      = req_write;
          end
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (is_write_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b0;
            resp_rdata_d = 32'd0;
          end else begin
            state_d = DATA;
          end
        end else if (wait_expired) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_rdata_d = 32'd0;
        end else if (WAIT_LIMIT != 0) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = extract(size_q, signed_q, offset_q, bus.readdata);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any transfer in flight without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      is_write_q   <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      offset_q     <= 2'b00;
      address_q    <= 32'd0;
      byteenable_q <= 4'b0000;
      writedata_q  <= 32'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      is_write_q   <= is_write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      offset_q     <= offset_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_fault     = resp_fault_q;
  assign resp_rdata     = resp_rdata_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.byteenable = byteenable_q;
  assign bus.writedata  = writedata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (WAIT_LIMIT = 4). The bench plays the
// bus slave itself: it stalls a chosen number of cycles and returns readdata
// only in the cycle after the read is accepted.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  int checks = 0;
  int passed = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.WAIT_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
  } vec_t;

  // Issues one request and acts as slave until the response (40-cycle bound).
  // lat is the cycle count from the accept edge to the edge sampling resp_valid,
  // -1 if no response arrived. Returns one cycle after the response pulse.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rd,
                           output int lat, output int rd_cyc, output int wr_cyc,
                           output logic [31:0] s_addr, output logic [3:0] s_be,
                           output logic [31:0] s_wd, output logic [31:0] r_rdata,
                           output logic r_fault);
    int   strobes;
    logic acc_prev;
    bit   done;
    lat = -1; rd_cyc = 0; wr_cyc = 0;
    s_addr = '0; s_be = '0; s_wd = '0; r_rdata = '0; r_fault = 1'b0;
    strobes = 0; acc_prev = 1'b0; done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_if.readdata = acc_prev ? rd : 32'hA5A5A5A5;
      acc_prev = 1'b0;
      if (bus_if.read || bus_if.write) begin
        strobes++;
        if (bus_if.read)  rd_cyc++;
        if (bus_if.write) wr_cyc++;
        if (strobes == 1) begin
          s_addr = bus_if.address; s_be = bus_if.byteenable; s_wd = bus_if.writedata;
        end
        bus_if.waitrequest = (strobes <= waits);
        acc_prev = bus_if.read && !bus_if.waitrequest;
      end else begin
        bus_if.waitrequest = 1'b0;
      end
      if (resp_valid) begin
        lat = c + 1; r_rdata = resp_rdata; r_fault = resp_fault; done = 1'b1;
      end
      @(negedge clk);
    end
    bus_if.waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset req_ready: got %b expected 1", req_ready); else passed++;
    checks++; if (bus_if.read !== 1'b0) $display("[TB] FAIL reset read: got %b expected 0", bus_if.read); else passed++;
    checks++; if (bus_if.write !== 1'b0) $display("[TB] FAIL reset write: got %b expected 0", bus_if.write); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset resp_valid: got %b expected 0", resp_valid); else passed++;
    checks++; if (resp_fault !== 1'b0) $display("[TB] FAIL reset resp_fault: got %b expected 0", resp_fault); else passed++;
    checks++; if (resp_rdata !== 32'd0) $display("[TB] FAIL reset resp_rdata: got %h expected 0", resp_rdata); else passed++;
    checks++; if (bus_if.address !== 32'd0) $display("[TB] FAIL reset address: got %h expected 0", bus_if.address); else passed++;
    checks++; if (bus_if.byteenable !== 4'b0000) $display("[TB] FAIL reset byteenable: got %b expected 0000", bus_if.byteenable); else passed++;
    checks++; if (bus_if.writedata !== 32'd0) $display("[TB] FAIL reset writedata: got %h expected 0", bus_if.writedata); else passed++;
  endtask

  task automatic test_store_word();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    do_access(1'b1, 2'b10, 1'b0, 32'hBFC00010, 32'hDEADBEEF, 0, 32'h0, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (lat !== 2) $display("[TB] FAIL store_word latency: got %0d expected 2", lat); else passed++;
    checks++; if (wc !== 1 || rc !== 0) $display("[TB] FAIL store_word strobes: got wr=%0d rd=%0d expected wr=1 rd=0", wc, rc); else passed++;
    checks++; if (a !== 32'hBFC00010) $display("[TB] FAIL store_word address: got %h expected bfc00010", a); else passed++;
    checks++; if (be !== 4'b1111) $display("[TB] FAIL store_word byteenable: got %b expected 1111", be); else passed++;
    checks++; if (wd !== 32'hDEADBEEF) $display("[TB] FAIL store_word writedata: got %h expected deadbeef", wd); else passed++;
    checks++; if (f !== 1'b0 || rdt !== 32'd0) $display("[TB] FAIL store_word resp: got fault=%b rdata=%h expected 0/0", f, rdt); else passed++;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL store_word pulse: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); else passed++;
  endtask

  task automatic test_load_byte();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    do_access(1'b0, 2'b00, 1'b1, 32'hBFC00013, 32'h0, 0, 32'h80112233, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (lat !== 3) $display("[TB] FAIL load_byte latency: got %0d expected 3", lat); else passed++;
    checks++; if (rc !== 1 || wc !== 0) $display("[TB] FAIL load_byte strobes: got rd=%0d wr=%0d expected rd=1 wr=0", rc, wc); else passed++;
    checks++; if (a !== 32'hBFC00010) $display("[TB] FAIL load_byte address: got %h expected bfc00010", a); else passed++;
    checks++; if (be !== 4'b1000) $display("[TB] FAIL load_byte byteenable: got %b expected 1000", be); else passed++;
    checks++; if (rdt !== 32'hFFFFFF80 || f !== 1'b0) $display("[TB] FAIL load_byte signed: got %h fault=%b expected ffffff80/0", rdt, f); else passed++;
    checks++; if (resp_rdata !== 32'hFFFFFF80) $display("[TB] FAIL load_byte hold: got %h expected ffffff80", resp_rdata); else passed++;
    do_access(1'b0, 2'b00, 1'b0, 32'hBFC00013, 32'h0, 0, 32'h80112233, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (rdt !== 32'h00000080) $display("[TB] FAIL load_byte unsigned: got %h expected 00000080", rdt); else passed++;
  endtask

  task automatic test_store_half_wait();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    do_access(1'b1, 2'b01, 1'b0, 32'hBFC00002, 32'h00001234, 3, 32'h0, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (wc !== 4) $display("[TB] FAIL store_half write cycles: got %0d expected 4", wc); else passed++;
    checks++; if (be !== 4'b1100) $display("[TB] FAIL store_half byteenable: got %b expected 1100", be); else passed++;
    checks++; if (wd !== 32'h12341234) $display("[TB] FAIL store_half writedata: got %h expected 12341234", wd); else passed++;
    checks++; if (a !== 32'hBFC00000) $display("[TB] FAIL store_half address: got %h expected bfc00000", a); else passed++;
    checks++; if (lat !== 5 || f !== 1'b0) $display("[TB] FAIL store_half latency: got %0d fault=%b expected 5/0", lat, f); else passed++;
  endtask

  task automatic test_lanes();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    vec_t v [9];
    v[0] = '{1'b1, 2'b00, 1'b0, 32'h00001001, 32'hFFFFFFAB, 32'h0,        4'b0010, 32'hABABABAB};
    v[1] = '{1'b1, 2'b00, 1'b0, 32'h00002000, 32'h123456CD, 32'h0,        4'b0001, 32'hCDCDCDCD};
    v[2] = '{1'b1, 2'b01, 1'b0, 32'h00003000, 32'hFFFF5678, 32'h0,        4'b0011, 32'h56785678};
    v[3] = '{1'b0, 2'b01, 1'b1, 32'h00004000, 32'h0,        32'h12348765, 4'b0011, 32'hFFFF8765};
    v[4] = '{1'b0, 2'b01, 1'b0, 32'h00004002, 32'h0,        32'h9ABC1234, 4'b1100, 32'h00009ABC};
    v[5] = '{1'b0, 2'b00, 1'b1, 32'h00005002, 32'h0,        32'h00C30000, 4'b0100, 32'hFFFFFFC3};
    v[6] = '{1'b0, 2'b00, 1'b1, 32'h00005001, 32'h0,        32'h00007F00, 4'b0010, 32'h0000007F};
    v[7] = '{1'b0, 2'b10, 1'b1, 32'h00006000, 32'h0,        32'h80112233, 4'b1111, 32'h80112233};
    v[8] = '{1'b1, 2'b11, 1'b0, 32'h00007000, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D};
    for (int i = 0; i < 9; i++) begin
      do_access(v[i].wr, v[i].sz, v[i].sg, v[i].addr, v[i].wdata, 0, v[i].rd, lat, rc, wc, a, be, wd, rdt, f);
      checks++; if (be !== v[i].exp_be) $display("[TB] FAIL lanes[%0d] byteenable: got %b expected %b", i, be, v[i].exp_be); else passed++;
      checks++; if (lat !== (v[i].wr ? 2 : 3)) $display("[TB] FAIL lanes[%0d] latency: got %0d expected %0d", i, lat, v[i].wr ? 2 : 3); else passed++;
      if (v[i].wr) begin
        checks++; if (wd !== v[i].exp_data || rdt !== 32'd0) $display("[TB] FAIL lanes[%0d] store: got wd=%h rdata=%h expected %h/0", i, wd, rdt, v[i].exp_data); else passed++;
      end else begin
        checks++; if (rdt !== v[i].exp_data || f !== 1'b0) $display("[TB] FAIL lanes[%0d] load: got %h fault=%b expected %h/0", i, rdt, f, v[i].exp_data); else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    do_access(1'b0, 2'b10, 1'b0, 32'h00008000, 32'h0, 3, 32'h11223344, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (rc !== 4 || lat !== 6) $display("[TB] FAIL wait_boundary timing: got rd=%0d lat=%0d expected 4/6", rc, lat); else passed++;
    checks++; if (f !== 1'b0 || rdt !== 32'h11223344) $display("[TB] FAIL wait_boundary resp: got fault=%b rdata=%h expected 0/11223344", f, rdt); else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h00009000, 32'h0, 100, 32'h55667788, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (rc !== 4) $display("[TB] FAIL timeout read cycles: got %0d expected 4", rc); else passed++;
    checks++; if (lat !== 5) $display("[TB] FAIL timeout latency: got %0d expected 5", lat); else passed++;
    checks++; if (f !== 1'b1 || rdt !== 32'd0) $display("[TB] FAIL timeout resp: got fault=%b rdata=%h expected 1/0", f, rdt); else passed++;
    checks++; if (bus_if.read !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL timeout idle: got read=%b ready=%b expected 0/1", bus_if.read, req_ready); else passed++;
  endtask

  task automatic test_misaligned();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    do_access(1'b0, 2'b10, 1'b0, 32'hBFC00001, 32'h0, 0, 32'hA1B2C3D4, lat, rc, wc, a, be, wd, rdt, f);
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (rc !== 0) $display("[TB] FAIL misaligned word strobe: got %0d read cycles expected 0", rc); else passed++;
    checks++; if (lat !== 1) $display("[TB] FAIL misaligned word latency: got %0d expected 1", lat); else passed++;
    checks++; if (f !== 1'b1 || rdt !== 32'd0) $display("[TB] FAIL misaligned word resp: got fault=%b rdata=%h expected 1/0", f, rdt); else passed++;
`else
    checks++; if (rc !== 1 || a !== 32'hBFC00000) $display("[TB] FAIL unaligned word bus: got rd=%0d addr=%h expected 1/bfc00000", rc, a); else passed++;
    checks++; if (be !== 4'b1111 || lat !== 3) $display("[TB] FAIL unaligned word be/lat: got %b/%0d expected 1111/3", be, lat); else passed++;
    checks++; if (f !== 1'b0 || rdt !== 32'hA1B2C3D4) $display("[TB] FAIL unaligned word resp: got fault=%b rdata=%h expected 0/a1b2c3d4", f, rdt); else passed++;
`endif
    do_access(1'b0, 2'b01, 1'b0, 32'h00000101, 32'h0, 0, 32'h0000BEEF, lat, rc, wc, a, be, wd, rdt, f);
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (rc !== 0 || f !== 1'b1 || lat !== 1) $display("[TB] FAIL misaligned half: got rd=%0d fault=%b lat=%0d expected 0/1/1", rc, f, lat); else passed++;
`else
    checks++; if (be !== 4'b0011 || rdt !== 32'h0000BEEF || f !== 1'b0) $display("[TB] FAIL unaligned half: got be=%b rdata=%h fault=%b expected 0011/0000beef/0", be, rdt, f); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    int lat, rc, wc; logic [31:0] a, wd, rdt; logic [3:0] be; logic f;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h00000100; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    bus_if.waitrequest = 1'b1;
    checks++; if (bus_if.read !== 1'b1 || req_ready !== 1'b0) $display("[TB] FAIL reset_mid busy: got read=%b ready=%b expected 1/0", bus_if.read, req_ready); else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus_if.read !== 1'b0 || resp_valid !== 1'b0) $display("[TB] FAIL reset_mid async: got read=%b valid=%b expected 0/0", bus_if.read, resp_valid); else passed++;
    @(negedge clk);
    reset = 1'b0;
    bus_if.waitrequest = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || bus_if.read) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL reset_mid abandoned: got activity=%b expected 0", seen); else passed++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_mid ready: got %b expected 1", req_ready); else passed++;
    do_access(1'b1, 2'b10, 1'b0, 32'h00000200, 32'h01020304, 0, 32'h0, lat, rc, wc, a, be, wd, rdt, f);
    checks++; if (lat !== 2 || wc !== 1 || wd !== 32'h01020304) $display("[TB] FAIL reset_mid next: got lat=%0d wr=%0d wd=%h expected 2/1/01020304", lat, wc, wd); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_store_word();
    test_load_byte();
    test_store_half_wait();
    test_lanes();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
